// File: rtl/encoder_layer_1_attention_self_query_bias_sink.sv
// Query-bias parameter sink: packs handshaked beats into an on-chip word memory
// and serves the stored words on a 2-cycle-latency read port.
module encoder_layer_1_attention_self_query_bias_sink #(
    parameter int QUERY_BIAS_TENSOR_SIZE_DIM_0 = 32,
    parameter int QUERY_BIAS_TENSOR_SIZE_DIM_1 = 1,
    parameter int QUERY_BIAS_PRECISION_0       = 16,
    parameter int QUERY_BIAS_PRECISION_1       = 3,
    parameter int QUERY_BIAS_PARALLELISM_DIM_0 = 4,
    parameter int QUERY_BIAS_PARALLELISM_DIM_1 = 1,
    parameter int IN_DEPTH = (QUERY_BIAS_TENSOR_SIZE_DIM_0 * QUERY_BIAS_TENSOR_SIZE_DIM_1)
                           / (QUERY_BIAS_PARALLELISM_DIM_0 * QUERY_BIAS_PARALLELISM_DIM_1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [QUERY_BIAS_PRECISION_0-1:0]      data_in [QUERY_BIAS_PARALLELISM_DIM_0*QUERY_BIAS_PARALLELISM_DIM_1],
    input  logic                                   data_in_valid,
    output logic                                   data_in_ready,
    input  logic                                   reload,
    output logic                                   load_done,
    output logic [$clog2(IN_DEPTH):0]              beat_count,
    input  logic                                   rd_en,
    input  logic [$clog2(IN_DEPTH):0]              rd_addr,
    output logic [QUERY_BIAS_PRECISION_0*QUERY_BIAS_PARALLELISM_DIM_0*QUERY_BIAS_PARALLELISM_DIM_1-1:0] rd_data,
    output logic                                   rd_valid
);

    localparam int PAR    = QUERY_BIAS_PARALLELISM_DIM_0 * QUERY_BIAS_PARALLELISM_DIM_1;
    localparam int WORD_W = QUERY_BIAS_PRECISION_0 * PAR;
    localparam int CNT_W  = $clog2(IN_DEPTH) + 1;
    localparam int PTR_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(IN_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_COUNT = CNT_W'(IN_DEPTH);

    // Fractional bits only describe the fixed-point format; data passes through untouched.
    if (QUERY_BIAS_PRECISION_1 > QUERY_BIAS_PRECISION_0) begin : g_frac_wider_than_element
    end

    typedef enum logic {LOAD, DONE} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]   beat_count_reg, beat_count_next;
    logic               ready_reg;
    logic               accept;
    logic               wr_en;
    logic [WORD_W-1:0]  beat_word;

    logic [WORD_W-1:0]  mem [IN_DEPTH];
    logic [WORD_W-1:0]  rd_word_reg;
    logic               rd_in_range;
    logic [PTR_W-1:0]   rd_idx;
    logic               rd_stage_valid_reg;
    logic               rd_stage_oob_reg;
    logic               rd_valid_reg;
    logic [WORD_W-1:0]  rd_data_reg;

    // Element j lands at bits [P0*j +: P0], mirroring how the source blocks unpack.
    for (genvar gi = 0; gi < PAR; gi++) begin : g_pack
        assign beat_word[QUERY_BIAS_PRECISION_0*gi +: QUERY_BIAS_PRECISION_0] = data_in[gi];
    end

    assign accept = data_in_valid && ready_reg;

    always_comb begin
        state_next      = state_reg;
        wr_ptr_next     = wr_ptr_reg;
        beat_count_next = beat_count_reg;
        wr_en           = 1'b0;
        case (state_reg)
            LOAD: begin
                // reload wins over a beat accepted in the same cycle
                if (reload) begin
                    wr_ptr_next     = '0;
                    beat_count_next = '0;
                end else if (accept) begin
                    wr_en           = 1'b1;
                    beat_count_next = beat_count_reg + CNT_W'(1);
                    if (wr_ptr_reg == LAST_PTR) begin
                        wr_ptr_next     = '0;
                        beat_count_next = DEPTH_COUNT;
                        state_next      = DONE;
                    end else begin
                        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
                    end
                end
            end
            DONE: begin
                if (reload) begin
                    state_next      = LOAD;
                    wr_ptr_next     = '0;
                    beat_count_next = '0;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= LOAD;
            wr_ptr_reg     <= '0;
            beat_count_reg <= '0;
            ready_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_ptr_reg     <= wr_ptr_next;
            beat_count_reg <= beat_count_next;
            ready_reg      <= (state_next == LOAD);
        end
    end

    // Memory is deliberately left out of reset so a reset does not lose loaded words.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_ptr_reg] <= beat_word;
        end
    end

    assign rd_in_range = (rd_addr < DEPTH_COUNT);
    assign rd_idx      = rd_in_range ? rd_addr[PTR_W-1:0] : '0;

    always_ff @(posedge clk) begin
        rd_word_reg <= mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_stage_valid_reg <= 1'b0;
            rd_stage_oob_reg   <= 1'b0;
            rd_valid_reg       <= 1'b0;
            rd_data_reg        <= '0;
        end else begin
            rd_stage_valid_reg <= rd_en;
            rd_stage_oob_reg   <= !rd_in_range;
            rd_valid_reg       <= rd_stage_valid_reg;
            if (rd_stage_valid_reg) begin
                rd_data_reg <= rd_stage_oob_reg ? '0 : rd_word_reg;
            end
        end
    end

    assign data_in_ready = ready_reg;
    assign load_done     = (state_reg == DONE);
    assign beat_count    = beat_count_reg;
    assign rd_data       = rd_data_reg;
    assign rd_valid      = rd_valid_reg;

endmodule
